// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the single-ported RAM between instruction fetch and MEM-stage data
// accesses, sequencing each access through a wait-state FSM with timeout detection.
module pipe_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready,
   output logic              ihit,
   output logic [DATA_W-1:0] iload,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   output logic              ramREN,
   output logic              ramWEN,
   output logic              mem_enable,
   output logic              fetch_stall,
   output logic              err
);

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DACC = 2'b01,
      IACC = 2'b10,
      ERR  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_d_q, last_d_d;
   logic             err_q, err_d;
   logic             d_req;

   assign d_req = dREN | dWEN;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_d_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_d_q <= last_d_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d_d = last_d_q;
      err_d    = err_q;
      ihit     = 1'b0;
      dhit     = 1'b0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;

      case (state_q)
         IDLE: begin
            // Round-robin on contention: the side that did not win last time goes first
            if (d_req && iREN) begin
               state_d = last_d_q ? IACC : DACC;
               cnt_d   = '0;
            end else if (d_req) begin
               state_d = DACC;
               cnt_d   = '0;
            end else if (iREN) begin
               state_d = IACC;
               cnt_d   = '0;
            end
         end

         DACC: begin
            if (!d_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = ~dWEN;
               if (ram_ready) begin
                  dhit     = 1'b1;
                  last_d_d = 1'b1;
                  state_d  = IDLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end
               end
            end
         end

         IACC: begin
            if (!iREN) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               if (ram_ready) begin
                  ihit     = 1'b1;
                  last_d_d = 1'b0;
                  state_d  = IDLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_d = ERR;
                     err_d   = 1'b1;
                  end
               end
            end
         end

         ERR: begin
            err_d = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign iload       = ramload;
   assign dload       = ramload;
   assign mem_enable  = ~d_req | dhit;
   assign fetch_stall = iREN & ~ihit;
   assign err         = err_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed testbench for pipe_mem_arbiter: reset, fetch, data priority,
// alternation, abort and timeout scenarios with hand-computed expectations.
module tb_pipe_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              iREN, dREN, dWEN, ram_ready;
   logic [ADDR_W-1:0] iaddr, daddr;
   logic [DATA_W-1:0] dstore, ramload;
   logic              ihit, dhit, ramREN, ramWEN, mem_enable, fetch_stall, err;
   logic [DATA_W-1:0] iload, dload, ramstore;
   logic [ADDR_W-1:0] ramaddr;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .ramload(ramload), .ram_ready(ram_ready),
      .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
      .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
      .mem_enable(mem_enable), .fetch_stall(fetch_stall), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      #2;
      n_checks++;
      if ({ramREN, ramWEN, ihit, dhit, err} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ramREN, ramWEN, ihit, dhit, err});
      end
      n_checks++;
      if (ramaddr !== '0 || ramstore !== '0) begin
         n_fail++; $display("FAIL reset_bus: got addr %h store %h want 0 0", ramaddr, ramstore);
      end
      tick(); tick();
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_access();
      dWEN = 1; daddr = 32'h10; dstore = 32'h55;
      tick();
      #1;
      n_checks++;
      if (ramWEN !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_pre: ramWEN got %b want 1", ramWEN);
      end
      nRST = 1'b0;
      #1;
      n_checks++;
      if ({ramWEN, ramREN, dhit, ihit, err} !== 5'b0) begin
         n_fail++; $display("FAIL rst_mid_async: got %b want 00000", {ramWEN, ramREN, dhit, ihit, err});
      end
      dWEN = 0;
      tick();
      nRST = 1'b1;
      tick(); tick();
      #1;
      n_checks++;
      if ({ramWEN, ramREN, dhit, ihit, err, mem_enable, fetch_stall} !== 7'b0000010) begin
         n_fail++; $display("FAIL rst_mid_idle: got %b want 0000010",
                            {ramWEN, ramREN, dhit, ihit, err, mem_enable, fetch_stall});
      end
   endtask

   task automatic test_ifetch();
      iREN = 1; iaddr = 32'h40; ram_ready = 0; ramload = 32'hDEADBEEF;
      #1;
      n_checks++;
      if (ramREN !== 1'b0 || fetch_stall !== 1'b1) begin
         n_fail++; $display("FAIL ifetch_idle: ramREN %b stall %b want 0 1", ramREN, fetch_stall);
      end
      tick(); // cycle N+1
      #1;
      n_checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
         n_fail++; $display("FAIL ifetch_n1: ren %b addr %h ihit %b want 1 00000040 0", ramREN, ramaddr, ihit);
      end
      tick(); // cycle N+2
      #1;
      n_checks++;
      if (ramREN !== 1'b1 || ihit !== 1'b0) begin
         n_fail++; $display("FAIL ifetch_n2: ren %b ihit %b want 1 0", ramREN, ihit);
      end
      tick(); // cycle N+3
      ram_ready = 1;
      #1;
      n_checks++;
      if (ihit !== 1'b1 || iload !== 32'hDEADBEEF || fetch_stall !== 1'b0) begin
         n_fail++; $display("FAIL ifetch_hit: ihit %b iload %h stall %b want 1 deadbeef 0", ihit, iload, fetch_stall);
      end
      tick();
      iREN = 0; ram_ready = 0;
      #1;
      n_checks++;
      if (ramREN !== 1'b0 || ihit !== 1'b0) begin
         n_fail++; $display("FAIL ifetch_after: ren %b ihit %b want 0 0", ramREN, ihit);
      end
   endtask

   task automatic test_d_priority();
      dWEN = 1; daddr = 32'h100; dstore = 32'h1234; iREN = 1; iaddr = 32'h200; ram_ready = 0;
      #1;
      n_checks++;
      if (mem_enable !== 1'b0) begin
         n_fail++; $display("FAIL prio_men_idle: got %b want 0", mem_enable);
      end
      tick();
      #1;
      n_checks++;
      if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h100) begin
         n_fail++; $display("FAIL prio_dacc: wen %b ren %b store %h addr %h want 1 0 00001234 00000100",
                            ramWEN, ramREN, ramstore, ramaddr);
      end
      n_checks++;
      if (mem_enable !== 1'b0 || dhit !== 1'b0) begin
         n_fail++; $display("FAIL prio_men_wait: men %b dhit %b want 0 0", mem_enable, dhit);
      end
      ram_ready = 1;
      #1;
      n_checks++;
      if (dhit !== 1'b1 || mem_enable !== 1'b1 || ihit !== 1'b0) begin
         n_fail++; $display("FAIL prio_dhit: dhit %b men %b ihit %b want 1 1 0", dhit, mem_enable, ihit);
      end
      tick();
      dWEN = 0; ram_ready = 0;
      #1;
      n_checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || fetch_stall !== 1'b1) begin
         n_fail++; $display("FAIL prio_gap: ren %b wen %b stall %b want 0 0 1", ramREN, ramWEN, fetch_stall);
      end
      tick();
      ram_ready = 1;
      #1;
      n_checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h200 || ihit !== 1'b1) begin
         n_fail++; $display("FAIL prio_iacc: ren %b addr %h ihit %b want 1 00000200 1", ramREN, ramaddr, ihit);
      end
      tick();
      iREN = 0; ram_ready = 0;
   endtask

   task automatic test_back_to_back();
      logic exp_d [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic exp_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      iREN = 1; dREN = 1; iaddr = 32'h300; daddr = 32'h400; ram_ready = 1;
      for (int c = 0; c < 6; c++) begin
         tick();
         #1;
         n_checks++;
         if (dhit !== exp_d[c] || ihit !== exp_i[c]) begin
            n_fail++; $display("FAIL b2b_cycle%0d: dhit %b ihit %b want %b %b", c, dhit, ihit, exp_d[c], exp_i[c]);
         end
      end
      iREN = 0; dREN = 0; ram_ready = 0;
      tick();
   endtask

   task automatic test_abort();
      dREN = 1; daddr = 32'h500; ram_ready = 0;
      tick();
      #1;
      n_checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
         n_fail++; $display("FAIL abort_c1: ren %b addr %h want 1 00000500", ramREN, ramaddr);
      end
      tick();
      dREN = 0; ram_ready = 1;
      #1;
      n_checks++;
      if (dhit !== 1'b0 || ramREN !== 1'b0) begin
         n_fail++; $display("FAIL abort_c2: dhit %b ren %b want 0 0", dhit, ramREN);
      end
      tick();
      #1;
      n_checks++;
      if ({dhit, ihit, ramREN, ramWEN} !== 4'b0) begin
         n_fail++; $display("FAIL abort_idle: got %b want 0000", {dhit, ihit, ramREN, ramWEN});
      end
      ram_ready = 0;
   endtask

   task automatic test_timeout();
      dREN = 1; daddr = 32'h600; ram_ready = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         #1;
         n_checks++;
         if (err !== 1'b0 || ramREN !== 1'b1) begin
            n_fail++; $display("FAIL timeout_acc%0d: err %b ren %b want 0 1", c, err, ramREN);
         end
      end
      tick();
      #1;
      n_checks++;
      if (err !== 1'b1 || ramREN !== 1'b0) begin
         n_fail++; $display("FAIL timeout_err: err %b ren %b want 1 0", err, ramREN);
      end
      ram_ready = 1; iREN = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         #1;
         n_checks++;
         if (err !== 1'b1 || dhit !== 1'b0 || ihit !== 1'b0 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            n_fail++; $display("FAIL timeout_sticky%0d: err %b dhit %b ihit %b ren %b wen %b want 1 0 0 0 0",
                               c, err, dhit, ihit, ramREN, ramWEN);
         end
      end
      dREN = 0; iREN = 0; ram_ready = 0;
      nRST = 1'b0;
      #1;
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_clear: err %b want 0", err);
      end
      tick();
      nRST = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_reset_mid_access();
      test_ifetch();
      test_d_priority();
      test_back_to_back();
      test_abort();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
